alu_req_arbiter: RTL and testbench

//  Shares one combinational ALU20 datapath between NREQ requesters. Round-robin

---
 rtl/alu_req_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin front end that time-shares one combinational ALU between NREQ requesters.
// Each operation runs IDLE (grant + latch) -> EXEC (ALU driven) -> RESP (held until accepted).
module alu_req_arbiter #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [4*NREQ-1:0]       req_op,
   input  logic [WIDTH*NREQ-1:0]   req_a,
   input  logic [WIDTH*NREQ-1:0]   req_b,
   input  logic [WIDTH*NREQ-1:0]   req_imm,
   input  logic [5*NREQ-1:0]       req_shamt,
   input  logic [NREQ-1:0]         req_cin,
   input  logic [NREQ-1:0]         req_signed,
   output logic [NREQ-1:0]         rsp_valid,
   input  logic [NREQ-1:0]         rsp_ready,
   output logic [WIDTH-1:0]        rsp_data,
   output logic [4:0]              rsp_flags,
   output logic                    alu_en,
   output logic [3:0]              alu_op,
   output logic [WIDTH-1:0]        src_a,
   output logic [WIDTH-1:0]        src_b,
   output logic [WIDTH-1:0]        imm_val,
   output logic [4:0]              shamt,
   output logic                    carry_in,
   output logic                    cmp_signed,
   input  logic [WIDTH-1:0]        alu_result,
   input  logic                    alu_zero,
   input  logic                    alu_carry,
   input  logic                    alu_ovf,
   input  logic                    alu_neg,
   output logic                    busy
);

   localparam int IDX_W = $clog2(NREQ);
   localparam logic [3:0] LAST_LEGAL_OP = 4'b1001;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic               run_q, run_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   imm_q, imm_d;
   logic [4:0]         shamt_q, shamt_d;
   logic               cin_q, cin_d;
   logic               sgn_q, sgn_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [4:0]         flags_q, flags_d;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W:0]     scan_sum;
   logic               grant;
   logic [3:0]         sel_op;
   logic [WIDTH-1:0]   sel_a, sel_b, sel_imm;
   logic [4:0]         sel_shamt;
   logic               sel_cin, sel_sgn;

   function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
      logic [IDX_W:0] nxt;
      nxt = {1'b0, idx} + (IDX_W+1)'(1);
      if (nxt >= (IDX_W+1)'(NREQ)) nxt = '0;
      return nxt[IDX_W-1:0];
   endfunction

   function automatic logic op_illegal(input logic [3:0] op);
      return (op > LAST_LEGAL_OP);
   endfunction

   // Scan starts at rr_ptr and wraps, so the last winner has lowest priority next time.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_sum  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (scan_sum >= (IDX_W+1)'(NREQ)) scan_sum = scan_sum - (IDX_W+1)'(NREQ);
         if (!win_found && req_valid[scan_sum[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_sum[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      sel_op    = '0;
      sel_a     = '0;
      sel_b     = '0;
      sel_imm   = '0;
      sel_shamt = '0;
      sel_cin   = 1'b0;
      sel_sgn   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDX_W'(i) == win_idx) begin
            sel_op    = req_op[4*i +: 4];
            sel_a     = req_a[WIDTH*i +: WIDTH];
            sel_b     = req_b[WIDTH*i +: WIDTH];
            sel_imm   = req_imm[WIDTH*i +: WIDTH];
            sel_shamt = req_shamt[5*i +: 5];
            sel_cin   = req_cin[i];
            sel_sgn   = req_signed[i];
         end
      end
   end

   // run_q keeps req_ready low until the first edge after reset release.
   assign grant = run_q && (state_q == S_IDLE) && win_found;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[win_idx] = 1'b1;
      rsp_valid = '0;
      if (state_q == S_RESP) rsp_valid[owner_q] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      run_d    = 1'b1;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      imm_d    = imm_q;
      shamt_d  = shamt_q;
      cin_d    = cin_q;
      sgn_d    = sgn_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               op_d     = sel_op;
               a_d      = sel_a;
               b_d      = sel_b;
               imm_d    = sel_imm;
               shamt_d  = sel_shamt;
               cin_d    = sel_cin;
               sgn_d    = sel_sgn;
               owner_d  = win_idx;
               rr_ptr_d = ptr_after(win_idx);
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            result_d = alu_result;
            flags_d  = {op_illegal(op_q), alu_neg, alu_ovf, alu_carry, alu_zero};
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready[owner_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         run_q    <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         shamt_q  <= '0;
         cin_q    <= 1'b0;
         sgn_q    <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         run_q    <= run_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         shamt_q  <= shamt_d;
         cin_q    <= cin_d;
         sgn_q    <= sgn_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   // ALU operands come straight from the latch registers; only alu_en is state-qualified.
   assign alu_en     = (state_q == S_EXEC);
   assign alu_op     = op_q;
   assign src_a      = a_q;
   assign src_b      = b_q;
   assign imm_val    = imm_q;
   assign shamt      = shamt_q;
   assign carry_in   = cin_q;
   assign cmp_signed = sgn_q;
   assign rsp_data   = result_q;
   assign rsp_flags  = flags_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural ALU on the datapath port
// and a queue-based response scoreboard.
module tb_alu_req_arbiter;

   localparam int WIDTH = 32;
   localparam int NREQ  = 4;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [4*NREQ-1:0]     req_op;
   logic [WIDTH*NREQ-1:0] req_a, req_b, req_imm;
   logic [5*NREQ-1:0]     req_shamt;
   logic [NREQ-1:0]       req_cin, req_signed;
   logic [NREQ-1:0]       rsp_valid, rsp_ready;
   logic [WIDTH-1:0]      rsp_data;
   logic [4:0]            rsp_flags;
   logic                  alu_en;
   logic [3:0]            alu_op;
   logic [WIDTH-1:0]      src_a, src_b, imm_val;
   logic [4:0]            shamt;
   logic                  carry_in, cmp_signed;
   logic [WIDTH-1:0]      alu_result;
   logic                  alu_zero, alu_carry, alu_ovf, alu_neg;
   logic                  busy;

   alu_req_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_imm(req_imm), .req_shamt(req_shamt),
      .req_cin(req_cin), .req_signed(req_signed),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
      .alu_en(alu_en), .alu_op(alu_op), .src_a(src_a), .src_b(src_b), .imm_val(imm_val),
      .shamt(shamt), .carry_in(carry_in), .cmp_signed(cmp_signed),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .alu_ovf(alu_ovf), .alu_neg(alu_neg), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 imm; others 0.
   logic [32:0] m_t;
   logic [31:0] m_r;
   logic        m_c, m_v;
   always_comb begin
      m_t = '0;
      m_r = '0;
      m_c = 1'b0;
      m_v = 1'b0;
      case (alu_op)
         4'd0: begin
            m_t = {1'b0, src_a} + {1'b0, src_b} + {32'b0, carry_in};
            m_r = m_t[31:0];
            m_c = m_t[32];
            m_v = (src_a[31] == src_b[31]) && (m_r[31] != src_a[31]);
         end
         4'd1: begin
            m_t = {1'b0, src_a} - {1'b0, src_b};
            m_r = m_t[31:0];
            m_c = m_t[32];
            m_v = (src_a[31] != src_b[31]) && (m_r[31] != src_a[31]);
         end
         4'd2: m_r = src_a & src_b;
         4'd3: m_r = src_a | src_b;
         4'd4: m_r = src_a ^ src_b;
         4'd5: m_r = src_a << shamt;
         4'd6: m_r = src_a >> shamt;
         4'd7: m_r = $signed(src_a) >>> shamt;
         4'd8: m_r = {31'b0, cmp_signed ? ($signed(src_a) < $signed(src_b)) : (src_a < src_b)};
         4'd9: m_r = imm_val;
         default: m_r = '0;
      endcase
   end
   assign alu_result = m_r;
   assign alu_zero   = (m_r == '0);
   assign alu_neg    = m_r[31];
   assign alu_carry  = m_c;
   assign alu_ovf    = m_v;

   typedef struct {
      int          owner;
      logic [31:0] data;
      logic [4:0]  flags;
      int          acc;
   } exp_t;

   exp_t        exp_q[$];
   int          grant_log[$];
   int          grant_cyc[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] edata_r[NREQ];
   logic [4:0]  eflags_r[NREQ];
   logic [NREQ-1:0] keep_r;
   logic [NREQ-1:0] snap_ready, snap_rvalid;
   logic [31:0] snap_data;
   logic [4:0]  snap_flags;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [4:0] sh,
                          input logic cin, input logic sgn, input logic [31:0] ed,
                          input logic [4:0] ef, input logic kp);
      req_op[i*4 +: 4]     = op;
      req_a[i*32 +: 32]    = a;
      req_b[i*32 +: 32]    = b;
      req_imm[i*32 +: 32]  = imm;
      req_shamt[i*5 +: 5]  = sh;
      req_cin[i]           = cin;
      req_signed[i]        = sgn;
      edata_r[i]           = ed;
      eflags_r[i]          = ef;
      keep_r[i]            = kp;
      req_valid[i]         = 1'b1;
   endtask

   // One clock: sample at negedge, record any handshake, drive again 1ns after posedge.
   task automatic tick();
      logic [NREQ-1:0] dropm;
      exp_t e;
      dropm = '0;
      @(negedge clk);
      snap_ready  = req_ready;
      snap_rvalid = rsp_valid;
      snap_data   = rsp_data;
      snap_flags  = rsp_flags;
      if (rst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               e.owner = i;
               e.data  = edata_r[i];
               e.flags = eflags_r[i];
               e.acc   = cyc;
               exp_q.push_back(e);
               grant_log.push_back(i);
               grant_cyc.push_back(cyc);
               if (!keep_r[i]) dropm[i] = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~dropm;
   endtask

   task automatic wait_grants(input int target, input string name);
      int b;
      b = 0;
      while (grant_log.size() < target && b < 50) begin
         tick();
         b++;
      end
      chk(name, grant_log.size(), target);
   endtask

   task automatic wait_idle(input string name);
      int b;
      b = 0;
      while ((exp_q.size() != 0 || busy || req_valid != '0) && b < 100) begin
         tick();
         b++;
      end
      chk(name, (exp_q.size() == 0 && !busy && req_valid == '0), 1);
   endtask

   // Response monitor: pops the scoreboard on every response handshake.
   logic        in_rsp = 1'b0;
   int          first_cyc = 0;
   logic [31:0] hold_data;
   logic [4:0]  hold_flags;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_rsp = 1'b0;
         end else if (rsp_valid != '0) begin
            if (!in_rsp) begin
               in_rsp     = 1'b1;
               first_cyc  = cyc;
               hold_data  = rsp_data;
               hold_flags = rsp_flags;
            end else begin
               chk("rsp_hold", {rsp_data, rsp_flags}, {hold_data, hold_flags});
            end
            if ((rsp_valid & rsp_ready) != '0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rsp", rsp_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_owner", rsp_valid, 4'(1) << e.owner);
                  chk("rsp_data", rsp_data, e.data);
                  chk("rsp_flags", rsp_flags, e.flags);
                  chk("rsp_latency", first_cyc - e.acc, 2);
               end
               in_rsp = 1'b0;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int exp_order[5] = '{0, 1, 2, 3, 0};
   int base;
   int bud;

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      req_imm    = '0;
      req_shamt  = '0;
      req_cin    = '0;
      req_signed = '0;
      rsp_ready  = '1;
      keep_r     = '0;
      for (int i = 0; i < NREQ; i++) begin
         edata_r[i]  = '0;
         eflags_r[i] = '0;
      end

      // Reset with every requester valid; req0 carries the single ADD.
      set_req(0, 4'd0, 32'd5, 32'd7, 32'd0, 5'd0, 1'b1, 1'b0, 32'd13, 5'b00000, 1'b0);
      set_req(1, 4'd0, 32'd1, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 32'd2, 5'b00000, 1'b0);
      set_req(2, 4'd0, 32'd1, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 32'd2, 5'b00000, 1'b0);
      set_req(3, 4'd0, 32'd1, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 32'd2, 5'b00000, 1'b0);
      tick();
      tick();
      chk("rst_ready", snap_ready, 0);
      chk("rst_rsp_valid", snap_rvalid, 0);
      chk("rst_ctrl", {busy, alu_en}, 0);
      chk("rst_rsp_data", {rsp_data, rsp_flags}, 0);
      chk("rst_alu_ops", {alu_op, src_a, shamt, carry_in, cmp_signed}, 0);
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_ready", snap_ready, 4'b0001);
      req_valid = '0;
      wait_idle("add_done");

      // Round robin from a fresh pointer.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_req(0, 4'd0, 32'd10, 32'd20, 32'd0, 5'd0, 1'b0, 1'b0, 32'd30, 5'b00000, 1'b1);
      set_req(1, 4'd1, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'b01010, 1'b1);
      set_req(2, 4'd2, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 5'd0, 1'b0, 1'b0, 32'h0000_00F0, 5'b00000, 1'b1);
      set_req(3, 4'd5, 32'd1, 32'd0, 32'd0, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 5'b01000, 1'b1);
      base = grant_log.size();
      wait_grants(base + 5, "rr_grants");
      req_valid = '0;
      keep_r    = '0;
      wait_idle("rr_done");
      if (grant_log.size() >= base + 5) begin
         for (int k = 0; k < 5; k++) chk("rr_order", grant_log[base+k], exp_order[k]);
         for (int k = 1; k < 5; k++) chk("rr_gap", grant_cyc[base+k] - grant_cyc[base+k-1], 3);
      end

      // Back-pressure on a SUB that yields zero; req0 waits behind it.
      rsp_ready = '0;
      set_req(2, 4'd1, 32'd3, 32'd3, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 5'b00001, 1'b0);
      wait_grants(grant_log.size() + 1, "bp_grant");
      set_req(0, 4'd0, 32'd100, 32'd23, 32'd0, 5'd0, 1'b0, 1'b0, 32'h7B, 5'b00000, 1'b0);
      bud = 0;
      while (snap_rvalid == '0 && bud < 10) begin
         tick();
         bud++;
      end
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp_valid", snap_rvalid, 4'b0100);
         chk("bp_rsp", {snap_data, snap_flags}, {32'd0, 5'b00001});
         chk("bp_req_ready", snap_ready, 0);
         tick();
      end
      rsp_ready = '1;
      wait_idle("bp_done");
      chk("bp_next_grant", grant_log[grant_log.size()-1], 0);

      // Illegal opcode.
      set_req(1, 4'b1100, 32'd7, 32'd9, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 5'b10001, 1'b0);
      wait_idle("illegal_done");

      // Reset while in EXEC: the in-flight op must vanish and the pointer restart at 0.
      set_req(1, 4'd0, 32'h11, 32'h22, 32'd0, 5'd0, 1'b0, 1'b0, 32'h33, 5'b00000, 1'b0);
      wait_grants(grant_log.size() + 1, "abort_grant");
      chk("exec_alu_en", {busy, alu_en}, 2'b11);
      chk("exec_operands", {alu_op, src_a, src_b}, {4'd0, 32'h11, 32'h22});
      rst_n = 1'b0;
      exp_q.delete();
      set_req(0, 4'd9, 32'd0, 32'd0, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0, 32'h0000_ABCD, 5'b00000, 1'b0);
      set_req(1, 4'd9, 32'd0, 32'd0, 32'h1, 5'd0, 1'b0, 1'b0, 32'h1, 5'b00000, 1'b0);
      set_req(2, 4'd9, 32'd0, 32'd0, 32'h2, 5'd0, 1'b0, 1'b0, 32'h2, 5'b00000, 1'b0);
      set_req(3, 4'd9, 32'd0, 32'd0, 32'h3, 5'd0, 1'b0, 1'b0, 32'h3, 5'b00000, 1'b0);
      tick();
      chk("abort_rsp_valid", snap_rvalid, 0);
      chk("abort_busy", {busy, alu_en}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("abort_no_rsp", snap_rvalid, 0);
      tick();
      chk("abort_rr_ptr", snap_ready, 4'b0001);
      req_valid = '0;
      wait_idle("abort_done");

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
